// File: rtl/chan_arb_pkg.sv
// Shared definitions for the channel transmit sequencer: default sizing,
// FSM state encoding and the header tag.
package chan_arb_pkg;

  localparam int N_CH_DEF      = 8;
  localparam int DW_DEF        = 8;
  localparam int MAX_BEATS_DEF = 16;

  localparam logic [4:0] HDR_TAG = 5'b10100;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    GAP
  } state_t;

  // Header beat identifies the owning channel under a fixed tag.
  function automatic logic [7:0] hdr_word(input logic [2:0] ch);
    return {HDR_TAG, ch};
  endfunction

endpackage

// File: rtl/channel_tx_sequencer_if.sv
// Downstream packet stream: valid/ready handshake with framing flags.
interface channel_tx_sequencer_if
  import chan_arb_pkg::*;
#(
  parameter int DW = DW_DEF
) ();

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eof;

  modport master (
    output out_valid,
    output out_data,
    output out_sof,
    output out_eof,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_sof,
    input  out_eof,
    output out_ready
  );

endinterface

// File: rtl/chan_sel_mux.sv
// N_CH:1 selector for the owning channel's current payload beat and last flag.
module chan_sel_mux
  import chan_arb_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic [2:0]         sel,
  input  logic [N_CH*DW-1:0] ch_data,
  input  logic [N_CH-1:0]    ch_last,
  output logic [DW-1:0]      sel_data,
  output logic               sel_last
);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (int'(sel) == c) begin
        sel_data = ch_data[c*DW +: DW];
        sel_last = ch_last[c];
      end
    end
  end

endmodule

// File: rtl/channel_tx_sequencer.sv
// Turns an arbiter grant into one framed packet: header, payload beats
// from the owning channel, then a one-cycle gap before the next grant.
module channel_tx_sequencer
  import chan_arb_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BEATS = MAX_BEATS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        id_req,
  input  logic [3:0]             grant,
  input  logic [N_CH*DW-1:0]     ch_data,
  input  logic [N_CH-1:0]        ch_last,
  output logic [N_CH-1:0]        ch_pop,
  channel_tx_sequencer_if.master tx,
  output logic                   abort,
  output logic                   busy,
  output logic [2:0]             cur_ch
);

  localparam logic [7:0] LAST_IDX = 8'(MAX_BEATS - 1);

  state_t        state, state_n;
  logic [2:0]    cur_ch_n;
  logic [7:0]    beat_cnt, beat_cnt_n;
  logic          grant_hit, cur_req, sel_last;
  logic [DW-1:0] sel_data;
  logic          out_valid, out_sof, out_eof;
  logic [DW-1:0] out_data;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Payload comes only through cur_ch, so grant never reaches out_data.
  chan_sel_mux #(
    .N_CH(N_CH),
    .DW  (DW)
  ) u_sel (
    .sel     (cur_ch),
    .ch_data (ch_data),
    .ch_last (ch_last),
    .sel_data(sel_data),
    .sel_last(sel_last)
  );

  always_comb begin
    grant_hit = 1'b0;
    cur_req   = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (int'(grant) == c)  grant_hit = id_req[c];
      if (int'(cur_ch) == c) cur_req   = id_req[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_ch   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      cur_ch   <= cur_ch_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cur_ch_n   = cur_ch;
    beat_cnt_n = beat_cnt;
    out_valid  = 1'b0;
    out_sof    = 1'b0;
    out_eof    = 1'b0;
    out_data   = '0;
    ch_pop     = '0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_hit) begin
          cur_ch_n = grant[2:0];
          state_n  = HEADER;
        end
      end
      HEADER: begin
        out_valid = 1'b1;
        out_sof   = 1'b1;
        out_data  = DW'(hdr_word(cur_ch));
        if (tx.out_ready) begin
          beat_cnt_n = '0;
          state_n    = DATA;
        end
      end
      DATA: begin
        if (!cur_req) begin
          abort   = 1'b1;
          state_n = GAP;
        end else begin
          out_valid = 1'b1;
          out_data  = sel_data;
          // Hitting the beat limit ends the packet cleanly; leftovers wait for a later grant.
          out_eof   = sel_last || (beat_cnt == LAST_IDX);
          if (tx.out_ready) begin
            for (int c = 0; c < N_CH; c++) begin
              ch_pop[c] = (int'(cur_ch) == c);
            end
            beat_cnt_n = sat_inc(beat_cnt);
            if (out_eof) state_n = GAP;
          end
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign tx.out_valid = out_valid;
  assign tx.out_sof   = out_sof;
  assign tx.out_eof   = out_eof;
  assign tx.out_data  = out_data;

endmodule

// File: doc/channel_tx_sequencer.md
CHANNEL_TX_SEQUENCER -- requirements
Module: channel_tx_sequencer

Interface
REQ-001 Parameter N_CH, default 8, number of requesting channels; grant encoding covers 0..N_CH-1.
REQ-002 Parameter DW, default 8, payload beat width in bits.
REQ-003 Parameter MAX_BEATS, default 16, maximum payload beats per packet; range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 id_req  input  N_CH  per-channel request lines, the same lines presented to the upstream arbiter.
REQ-007 grant  input  4  arbiter grant, registered upstream; values >= N_CH are invalid.
REQ-008 ch_data  input  N_CH*DW  channel c payload at bits [c*DW +: DW].
REQ-009 ch_last  input  N_CH  channel c current beat is its final beat.
REQ-010 ch_pop  output  N_CH  one-hot pulse; channel c advances to its next beat.
REQ-011 out_valid / out_ready  output / input  1 / 1  downstream handshake; a beat transfers when both are high.
REQ-012 out_data  output  DW  header or payload beat.
REQ-013 out_sof / out_eof  output  1 / 1  first / last beat of a packet, qualified by out_valid.
REQ-014 abort  output  1  one-cycle pulse; current packet is to be discarded downstream.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 cur_ch  output  3  channel currently owning the output.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, HEADER, DATA, GAP.
REQ-018 IDLE: grant < N_CH and id_req[grant] high -> latch cur_ch = grant[2:0], go HEADER next cycle; otherwise stay in IDLE. Invalid grant or non-requesting granted channel -> stay in IDLE.
REQ-019 HEADER: out_valid=1, out_sof=1, out_data = {HDR_TAG, cur_ch}, zero-extended to DW; hold until out_ready; on transfer go DATA with beat_cnt=0.
REQ-020 DATA: out_valid = id_req[cur_ch]; out_data = ch_data slice of cur_ch; no combinational path from grant to out_data.
REQ-021 DATA transfer: ch_pop[cur_ch]=1 in the same cycle; beat_cnt increments by 1, 8-bit, saturating, never wraps.
REQ-022 out_eof SHALL be high on a DATA beat when ch_last[cur_ch]=1 or beat_cnt == MAX_BEATS-1; that transfer goes to GAP.
REQ-023 MAX_BEATS truncation SHALL NOT pulse abort; the channel keeps its remaining beats for a later grant.
REQ-024 id_req[cur_ch] low in any DATA cycle -> abort=1 that cycle, no transfer, go GAP.
REQ-025 id_req[cur_ch] low in HEADER -> header still completes (valid held); the abort check runs from the first DATA cycle.
REQ-026 GAP: exactly one cycle, out_valid=0, then IDLE. This lets the registered arbiter re-evaluate before the next latch.
REQ-027 Grant changes while busy SHALL be ignored; ownership changes only in IDLE.
REQ-028 Latency: grant valid in IDLE cycle N -> header valid in cycle N+1 -> first payload beat no earlier than N+2.
REQ-029 Minimum packet occupancy is 3 cycles (HEADER, one DATA, GAP) with out_ready held high.
REQ-030 ch_pop SHALL be zero in every cycle without a DATA-state transfer.

Reset
REQ-031 rst_n low SHALL force, asynchronously: state=IDLE, cur_ch=0, beat_cnt=0, out_valid=0, out_sof=0, out_eof=0, ch_pop=0, abort=0, busy=0.
REQ-032 Reset mid-packet SHALL drop the packet silently, with no abort pulse; after release the block first samples grant in the first IDLE cycle.

Structure
REQ-033 Shared package chan_arb_pkg SHALL hold N_CH, DW, MAX_BEATS defaults, the state enum, and HDR_TAG (5'b10100).
REQ-034 Channel data/last selection SHALL be one sub-module, chan_sel_mux (N_CH:1, indexed by cur_ch); everything else stays flat.

Verification
REQ-035 Single packet: grant=3, id_req[3]=1, ch_last on 3rd beat, out_ready=1 -> header 0xA3 with sof, 3 beats, eof on beat 3, ch_pop[3] x3, GAP, IDLE.
REQ-036 Back-pressure: out_ready low 4 cycles during HEADER and 2 during DATA -> out_valid/out_data stable, no ch_pop while stalled.
REQ-037 Truncation: MAX_BEATS=16, ch_last never high -> eof on 16th beat, abort=0, channel re-granted and new header issued after GAP+IDLE.
REQ-038 Abort: id_req[5] drops after 2 payload beats -> abort one cycle, no eof, ch_pop count=2, GAP then IDLE.
REQ-039 Grant churn: grant changes 7->6->0 while busy on channel 7 -> cur_ch stays 7 until GAP; invalid grant=4'hF in IDLE -> no header.
REQ-040 Reset mid-DATA: rst_n low 1 cycle -> all outputs zero immediately, no abort, clean header on the next valid grant.
